mod_addsub_ctrl: RTL

Sequencer for modular addition and subtraction, (a ± b) mod m, on 16-bit operands. It shares one instance of the 16-bit block carry-lookahead adder, BCLA_ADD_16, across two passes: a raw add or subtract, then a correction. It sits in front of the moddiv datapath, which uses it for modular reduction steps. A start/busy/done handshake drives it, and it holds the result in a register.

---
 rtl/mod_addsub_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mod_addsub_ctrl.sv
// rtl/mod_addsub_ctrl.sv - two-pass modular add/subtract sequencer on a shared 16-bit block CLA

// 16-bit block carry-lookahead adder: four 4-bit groups, lookahead across groups, ripple inside a group.
module BCLA_ADD_16 (
    output logic [15:0] sum,
    output logic        c_out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;

    // Bit and group generate/propagate, group carries, then per-bit carries and sum.
    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int i = 0; i < 4; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i];
        end
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_in);
        c_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
        c = '0;
        for (int grp = 0; grp < 4; grp++) begin
            c[4*grp] = gc[grp];
            for (int j = 1; j < 4; j++) begin
                c[4*grp+j] = g[4*grp+j-1] | (p[4*grp+j-1] & c[4*grp+j-1]);
            end
        end
        sum = p ^ c;
    end

endmodule

// Sequencer: pass 1 forms a+b or a-b, pass 2 applies the modulus correction.
module mod_addsub_ctrl #(
    parameter int EARLY_DONE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] m,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2
    } state_t;

    localparam bit EARLY = (EARLY_DONE != 0);

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] m_q, m_d;
    logic        op_q, op_d;
    logic [15:0] s_q, s_d;
    logic        c1_q, c1_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;

    logic [15:0] add_x;
    logic [15:0] add_y;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        early_fin;

    BCLA_ADD_16 u_add (
        .sum   (add_sum),
        .c_out (add_cout),
        .a     (add_x),
        .b     (add_y),
        .c_in  (add_cin)
    );

    // Adder operand mux; IDLE drives zeros so the adder never sees stale or unknown inputs.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_q)
            PASS1: begin
                add_x   = a_q;
                add_y   = op_q ? ~b_q : b_q;
                add_cin = op_q;
            end
            PASS2: begin
                add_x   = s_q;
                add_y   = op_q ? m_q : ~m_q;
                add_cin = ~op_q;
            end
            default: ;
        endcase
    end

    // A subtraction with no borrow is already reduced; optionally finish after pass 1.
    assign early_fin = EARLY && op_q && add_cout;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            op_q     <= 1'b0;
            s_q      <= '0;
            c1_q     <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            op_q     <= op_d;
            s_q      <= s_d;
            c1_q     <= c1_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PASS1;
            PASS1:   state_d = early_fin ? IDLE : PASS2;
            PASS2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: operand latch, pass-1 capture, result selection and done pulse.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        op_d     = op_q;
        s_d      = s_q;
        c1_d     = c1_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d  = a;
                    b_d  = b;
                    m_d  = m;
                    op_d = op;
                end
            end
            PASS1: begin
                s_d  = add_sum;
                c1_d = add_cout;
                if (early_fin) begin
                    result_d = add_sum;
                    done_d   = 1'b1;
                end
            end
            PASS2: begin
                done_d = 1'b1;
                if (!op_q) begin
                    // Carry out of pass 1 or no borrow from s-m means the sum reached m.
                    result_d = (c1_q | add_cout) ? add_sum : s_q;
                end else begin
                    // A borrow in pass 1 means m must be added back (16-bit wrap intended).
                    result_d = c1_q ? s_q : add_sum;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = done_q;
        result = result_q;
    end

endmodule
